// File: rtl/dpu_axil_pkg.sv
// Shared register map, command-queue entry layout and dispatcher states for the
// AXI4-Lite to dpu_top PIO bridge.
package dpu_axil_pkg;

    localparam int PIO_ADDR_MAX = 24;

    localparam logic [7:0] REG_CMD      = 8'h00;
    localparam logic [7:0] REG_ADDR     = 8'h04;
    localparam logic [7:0] REG_WDATA    = 8'h08;
    localparam logic [7:0] REG_RDATA    = 8'h0C;
    localparam logic [7:0] REG_STATUS   = 8'h10;
    localparam logic [7:0] REG_PERF     = 8'h14;
    localparam logic [7:0] REG_IRQ_EN   = 8'h18;
    localparam logic [7:0] REG_IRQ_STAT = 8'h1C;
    localparam logic [7:0] REG_LEVEL    = 8'h20;
    localparam logic [7:0] REG_CTRL     = 8'h24;

    localparam int CMD_AUTO_INC_BIT = 8;
    localparam int CTRL_FLUSH_CMDQ  = 0;
    localparam int CTRL_FLUSH_RSPQ  = 1;

    localparam int IRQ_DONE   = 0;
    localparam int IRQ_RELOAD = 1;
    localparam int IRQ_DRAIN  = 2;
    localparam int IRQ_OVF    = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [2:0]              cmd_type;
        logic [PIO_ADDR_MAX-1:0] addr;
        logic [7:0]              data;
    } pio_cmd_t;

    typedef enum logic [1:0] {
        DISP_IDLE     = 2'd0,
        DISP_ISSUE    = 2'd1,
        DISP_WAIT_RSP = 2'd2
    } disp_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [1:0] lowest_lane(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic reg_known(input logic [7:0] off);
        logic k;
        case (off)
            REG_CMD, REG_ADDR, REG_WDATA, REG_RDATA, REG_STATUS, REG_PERF,
            REG_IRQ_EN, REG_IRQ_STAT, REG_LEVEL, REG_CTRL: k = 1'b1;
            default: k = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/dpu_axil_pio_bridge_fifo.sv
// Show-ahead synchronous FIFO with flush; one-cycle push-to-visible latency.
// Pushes to a full FIFO and pops from an empty one are ignored; flush beats a same-cycle pop.
module dpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, wr_slot;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Flush empties the queue first, so a same-cycle push lands in slot 0.
    assign do_push = push_i & (flush_i | ~full_o);
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign wr_slot = flush_i ? '0 : wr_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= do_push ? AW'(1) : '0;
            level_q  <= do_push ? (AW+1)'(1) : '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_slot] <= push_dat_i;
    end

endmodule

// File: rtl/dpu_axil_pio_bridge.sv
// AXI4-Lite slave queueing CPU writes as dpu_top PIO commands; B/R one cycle after handshake
// (WDATA: after last lane push). Backpressure: no new AW/W while B or a push burst is pending.
module dpu_axil_pio_bridge
    import dpu_axil_pkg::*;
#(
    parameter int         ADDR_BITS   = 24,
    parameter int         AXI_ADDR_W  = 6,
    parameter int         CMDQ_DEPTH  = 16,
    parameter int         RSPQ_DEPTH  = 8,
    parameter logic [2:0] RD_CMD_TYPE = 3'd2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AXI_ADDR_W-1:0] s_axi_awaddr_i,
    input  logic [2:0]            s_axi_awprot_i,
    input  logic                  s_axi_awvalid_i,
    output logic                  s_axi_awready_o,
    input  logic [31:0]           s_axi_wdata_i,
    input  logic [3:0]            s_axi_wstrb_i,
    input  logic                  s_axi_wvalid_i,
    output logic                  s_axi_wready_o,
    output logic [1:0]            s_axi_bresp_o,
    output logic                  s_axi_bvalid_o,
    input  logic                  s_axi_bready_i,
    input  logic [AXI_ADDR_W-1:0] s_axi_araddr_i,
    input  logic [2:0]            s_axi_arprot_i,
    input  logic                  s_axi_arvalid_i,
    output logic                  s_axi_arready_o,
    output logic [31:0]           s_axi_rdata_o,
    output logic [1:0]            s_axi_rresp_o,
    output logic                  s_axi_rvalid_o,
    input  logic                  s_axi_rready_i,
    output logic                  pio_cmd_valid_o,
    input  logic                  pio_cmd_ready_i,
    output logic [2:0]            pio_cmd_type_o,
    output logic [ADDR_BITS-1:0]  pio_cmd_addr_o,
    output logic [7:0]            pio_cmd_data_o,
    input  logic                  pio_rsp_valid_i,
    input  logic [7:0]            pio_rsp_data_i,
    input  logic                  dpu_busy_i,
    input  logic                  dpu_done_i,
    input  logic                  dpu_reload_req_i,
    input  logic [4:0]            dpu_current_layer_i,
    input  logic [31:0]           dpu_perf_cycles_i,
    output logic                  irq_o
);
    localparam int CQ_LW = $clog2(CMDQ_DEPTH) + 1;
    localparam int RQ_LW = $clog2(RSPQ_DEPTH) + 1;

    // Write channel and push sequencer state.
    logic                 awready_q, awready_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 push_busy_q, push_busy_d;
    logic [3:0]           lanes_q, lanes_d;
    logic [31:0]          wdat_q, wdat_d;
    logic [2:0]           cmd_type_q, cmd_type_d;
    logic                 auto_inc_q, auto_inc_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [3:0]           irq_en_q, irq_en_d;
    logic [3:0]           irq_stat_q, irq_stat_d;
    logic                 irq_q;
    logic                 done_q, reload_q, drain_q;

    // Read channel state.
    logic                 arready_q, rvalid_q;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;

    // Dispatcher state.
    disp_state_e          state_q, state_d;
    pio_cmd_t             cur_q, cur_d;

    logic                 cmdq_push, cmdq_pop, cmdq_flush, cmdq_full, cmdq_empty;
    logic [CQ_LW-1:0]     cmdq_level;
    pio_cmd_t             cmdq_in, cmdq_head;
    logic                 rspq_push, rspq_pop, rspq_flush, rspq_full, rspq_empty;
    logic [RQ_LW-1:0]     rspq_level;
    logic [7:0]           rspq_head;

    logic                 wr_hs, rd_hs, wr_is_wdata, wd_reject, rsp_drop, idle_empty;
    logic [7:0]           aw_off, ar_off;
    logic [2:0]           wstrb_n;
    logic [1:0]           cur_lane;
    logic [3:0]           irq_set, irq_w1c;
    logic [31:0]          rd_val;
    logic                 rd_legal;
    logic                 unused_prot;

    assign unused_prot = ^{s_axi_awprot_i, s_axi_arprot_i};

    assign aw_off      = 8'(s_axi_awaddr_i);
    assign ar_off      = 8'(s_axi_araddr_i);
    assign wr_hs       = awready_q & s_axi_awvalid_i & s_axi_wvalid_i;
    assign rd_hs       = arready_q & s_axi_arvalid_i;
    assign wr_is_wdata = wr_hs & (aw_off == REG_WDATA);
    assign wstrb_n     = popcount4(s_axi_wstrb_i);
    assign wd_reject   = (wstrb_n == 3'd0) ||
                         ({29'b0, wstrb_n} > (32'(CMDQ_DEPTH) - 32'(cmdq_level)));

    assign cmdq_flush  = wr_hs & (aw_off == REG_CTRL) & s_axi_wdata_i[CTRL_FLUSH_CMDQ];
    assign rspq_flush  = wr_hs & (aw_off == REG_CTRL) & s_axi_wdata_i[CTRL_FLUSH_RSPQ];

    assign cur_lane    = lowest_lane(lanes_q);
    assign cmdq_push   = push_busy_q & ~cmdq_full;
    assign cmdq_in     = '{cmd_type: cmd_type_q, addr: PIO_ADDR_MAX'(addr_q),
                           data: wdat_q[{cur_lane, 3'b000} +: 8]};

    always_comb begin
        awready_d   = s_axi_awvalid_i & s_axi_wvalid_i & ~awready_q & ~bvalid_q & ~push_busy_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        push_busy_d = push_busy_q;
        lanes_d     = lanes_q;
        wdat_d      = wdat_q;
        cmd_type_d  = cmd_type_q;
        auto_inc_d  = auto_inc_q;
        addr_d      = addr_q;
        irq_en_d    = irq_en_q;
        if (bvalid_q & s_axi_bready_i) bvalid_d = 1'b0;
        if (wr_hs) begin
            bresp_d = reg_known(aw_off) ? RESP_OKAY : RESP_SLVERR;
            if (wr_is_wdata & ~wd_reject) begin
                push_busy_d = 1'b1;
                lanes_d     = s_axi_wstrb_i;
                wdat_d      = s_axi_wdata_i;
            end else begin
                bvalid_d = 1'b1;
                if (wr_is_wdata) bresp_d = RESP_SLVERR;
            end
            case (aw_off)
                REG_CMD: begin
                    cmd_type_d = s_axi_wdata_i[2:0];
                    auto_inc_d = s_axi_wdata_i[CMD_AUTO_INC_BIT];
                end
                REG_ADDR:   addr_d   = s_axi_wdata_i[ADDR_BITS-1:0];
                REG_IRQ_EN: irq_en_d = s_axi_wdata_i[3:0];
                default: ;
            endcase
        end
        // One lane per cycle, lowest first; B follows the final lane.
        if (cmdq_push) begin
            lanes_d = lanes_q & ~(4'b0001 << cur_lane);
            if (auto_inc_q) addr_d = addr_q + ADDR_BITS'(1);
            if (lanes_d == 4'b0000) begin
                push_busy_d = 1'b0;
                bvalid_d    = 1'b1;
            end
        end
    end

    assign cmdq_pop   = (state_q == DISP_IDLE) & ~cmdq_empty & ~cmdq_flush;
    assign rspq_push  = (state_q == DISP_WAIT_RSP) & pio_rsp_valid_i;
    assign rsp_drop   = rspq_push & rspq_full & ~rspq_flush;
    assign rspq_pop   = rd_hs & (ar_off == REG_RDATA) & ~rspq_empty;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            DISP_IDLE: begin
                if (cmdq_pop) begin
                    state_d = DISP_ISSUE;
                    cur_d   = cmdq_head;
                end
            end
            DISP_ISSUE: begin
                if (pio_cmd_ready_i)
                    state_d = (cur_q.cmd_type == RD_CMD_TYPE) ? DISP_WAIT_RSP : DISP_IDLE;
            end
            DISP_WAIT_RSP: begin
                if (pio_rsp_valid_i) state_d = DISP_IDLE;
            end
            default: state_d = DISP_IDLE;
        endcase
    end

    // Drain interrupt fires once all queued work has been handed to the core.
    assign idle_empty = cmdq_empty & (state_q == DISP_IDLE);

    always_comb begin
        irq_set             = 4'b0000;
        irq_set[IRQ_DONE]   = dpu_done_i & ~done_q;
        irq_set[IRQ_RELOAD] = dpu_reload_req_i & ~reload_q;
        irq_set[IRQ_DRAIN]  = idle_empty & ~drain_q;
        irq_set[IRQ_OVF]    = (wr_is_wdata & wd_reject) | rsp_drop;
        irq_w1c             = (wr_hs && aw_off == REG_IRQ_STAT) ? s_axi_wdata_i[3:0] : 4'b0000;
        irq_stat_d          = (irq_stat_q & ~irq_w1c) | irq_set;
    end

    always_comb begin
        rd_val   = 32'h0;
        rd_legal = reg_known(ar_off);
        case (ar_off)
            REG_CMD:      rd_val = {23'b0, auto_inc_q, 5'b0, cmd_type_q};
            REG_ADDR:     rd_val = 32'(addr_q);
            REG_RDATA:    rd_val = {23'b0, ~rspq_empty, rspq_empty ? 8'h00 : rspq_head};
            REG_STATUS:   rd_val = {13'b0, cmdq_empty, pio_cmd_ready_i, dpu_reload_req_i,
                                    3'b0, dpu_current_layer_i, 6'b0, dpu_done_i, dpu_busy_i};
            REG_PERF:     rd_val = dpu_perf_cycles_i;
            REG_IRQ_EN:   rd_val = {28'b0, irq_en_q};
            REG_IRQ_STAT: rd_val = {28'b0, irq_stat_q};
            REG_LEVEL:    rd_val = {8'b0, 8'(rspq_level), 8'b0, 8'(cmdq_level)};
            default:      rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            push_busy_q <= 1'b0;
            lanes_q     <= '0;
            wdat_q      <= '0;
            cmd_type_q  <= '0;
            auto_inc_q  <= 1'b0;
            addr_q      <= '0;
            irq_en_q    <= '0;
            irq_stat_q  <= '0;
            irq_q       <= 1'b0;
            done_q      <= 1'b0;
            reload_q    <= 1'b0;
            drain_q     <= 1'b1;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            state_q     <= DISP_IDLE;
            cur_q       <= '0;
        end else begin
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            push_busy_q <= push_busy_d;
            lanes_q     <= lanes_d;
            wdat_q      <= wdat_d;
            cmd_type_q  <= cmd_type_d;
            auto_inc_q  <= auto_inc_d;
            addr_q      <= addr_d;
            irq_en_q    <= irq_en_d;
            irq_stat_q  <= irq_stat_d;
            irq_q       <= |(irq_en_q & irq_stat_q);
            done_q      <= dpu_done_i;
            reload_q    <= dpu_reload_req_i;
            drain_q     <= idle_empty;
            arready_q   <= s_axi_arvalid_i & ~rvalid_q & ~arready_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q & s_axi_rready_i) begin
                rvalid_q <= 1'b0;
            end
            state_q     <= state_d;
            cur_q       <= cur_d;
        end
    end

    dpu_sync_fifo #(.WIDTH($bits(pio_cmd_t)), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (cmdq_push),
        .push_dat_i (cmdq_in),
        .pop_i      (cmdq_pop),
        .flush_i    (cmdq_flush),
        .pop_dat_o  (cmdq_head),
        .full_o     (cmdq_full),
        .empty_o    (cmdq_empty),
        .level_o    (cmdq_level)
    );

    dpu_sync_fifo #(.WIDTH(8), .DEPTH(RSPQ_DEPTH)) u_rspq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (rspq_push),
        .push_dat_i (pio_rsp_data_i),
        .pop_i      (rspq_pop),
        .flush_i    (rspq_flush),
        .pop_dat_o  (rspq_head),
        .full_o     (rspq_full),
        .empty_o    (rspq_empty),
        .level_o    (rspq_level)
    );

    assign s_axi_awready_o = awready_q;
    assign s_axi_wready_o  = awready_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_arready_o = arready_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = rresp_q;
    assign pio_cmd_valid_o = (state_q == DISP_ISSUE);
    assign pio_cmd_type_o  = cur_q.cmd_type;
    assign pio_cmd_addr_o  = cur_q.addr[ADDR_BITS-1:0];
    assign pio_cmd_data_o  = cur_q.data;
    assign irq_o           = irq_q;

endmodule
